// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between two clients.
//
// Grants the master to one client at a time. While a client owns the master
// its control strobes and transmit byte are steered to the master, and the
// master's handshakes and received byte are steered back to that client only.
// Between owners the arbiter passes through DRAIN until the master reports
// ready. Ties in IDLE go to the client that did not own the master last.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req0/1                     client requests, held for the whole transaction
//   gnt0/1                     registered grants (never both high)
//   start/send/receive0/1      client control strobes
//   datasend0/1                client transmit bytes
//   sended0/1, received0/1     master handshakes, owner only
//   datareceive0/1             received byte, owner only (8'h00 otherwise)
//   m_start/m_send/m_receive   controls to the I2C master
//   m_datasend                 byte to the I2C master
//   m_ready/m_sended/m_received, m_datareceive   status from the I2C master
//   busy                       arbiter not in IDLE
//   owner                      index of the granted (or last granted) client
//   timeout                    one-cycle pulse on a forced release
//
// Build option: define I2C_ARB_TIMEOUT_EN to enable the inactivity timer that
// forcibly releases an owner after TIMEOUT_CYCLES idle cycles in OWN.

module i2c_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       start0,
  input  logic       start1,
  input  logic       send0,
  input  logic       send1,
  input  logic       receive0,
  input  logic       receive1,
  input  logic [7:0] datasend0,
  input  logic [7:0] datasend1,
  output logic       sended0,
  output logic       sended1,
  output logic       received0,
  output logic       received1,
  output logic [7:0] datareceive0,
  output logic [7:0] datareceive1,
  output logic       m_start,
  output logic       m_send,
  output logic       m_receive,
  output logic [7:0] m_datasend,
  input  logic       m_ready,
  input  logic       m_sended,
  input  logic       m_received,
  input  logic [7:0] m_datareceive,
  output logic       busy,
  output logic       owner,
  output logic       timeout
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_OWN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  logic [1:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       timeout_q, timeout_d;
  logic [1:0] req_v;
  logic       win;
  logic       owner_req;

  // Mux the owner's controls to the master; grants only exist in OWN, so
  // everything is 0 in IDLE/DRAIN and during reset.
  always_comb begin
    m_start    = 1'b0;
    m_send     = 1'b0;
    m_receive  = 1'b0;
    m_datasend = 8'h00;
    if (gnt_q[0]) begin
      m_start    = start0;
      m_send     = send0;
      m_receive  = receive0;
      m_datasend = datasend0;
    end else if (gnt_q[1]) begin
      m_start    = start1;
      m_send     = send1;
      m_receive  = receive1;
      m_datasend = datasend1;
    end
  end

  // Route master returns to the owner only.
  assign sended0      = m_sended & gnt_q[0];
  assign sended1      = m_sended & gnt_q[1];
  assign received0    = m_received & gnt_q[0];
  assign received1    = m_received & gnt_q[1];
  assign datareceive0 = gnt_q[0] ? m_datareceive : 8'h00;
  assign datareceive1 = gnt_q[1] ? m_datareceive : 8'h00;

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign busy    = (state_q != ST_IDLE);
  assign owner   = owner_q;
  assign timeout = timeout_q;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] timer_q, timer_d;
  logic [1:0]  blk_q, blk_d;
  logic        activity_c;

  assign activity_c = m_start | m_send | m_receive | m_sended | m_received;
  // A timed-out client stays blocked until its request is seen low.
  assign req_v      = {req1, req0} & ~blk_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign req_v              = {req1, req0};
`endif

  assign owner_req = owner_q ? req1 : req0;

  // Next-state logic for IDLE -> OWN -> DRAIN -> IDLE.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    timeout_d    = 1'b0;
    win          = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    timer_d      = 16'd0;
    blk_d        = blk_q & {req1, req0};
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = 2'b00;
        if (m_ready && (req_v != 2'b00)) begin
          // On a tie the client that did not own the master last wins.
          win     = (req_v == 2'b11) ? ~last_owner_q : req_v[1];
          state_d = ST_OWN;
          gnt_d   = win ? 2'b10 : 2'b01;
          owner_d = win;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          state_d      = ST_DRAIN;
          gnt_d        = 2'b00;
          last_owner_d = owner_q;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if ((timer_q == TIMEOUT_CYCLES - 16'd1) && !activity_c) begin
          state_d        = ST_DRAIN;
          gnt_d          = 2'b00;
          last_owner_d   = owner_q;
          timeout_d      = 1'b1;
          blk_d[owner_q] = 1'b1;
        end else begin
          timer_d = activity_c ? 16'd0 : timer_q + 16'd1;
        end
`endif
      end
      ST_DRAIN: begin
        gnt_d = 2'b00;
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      timeout_q    <= timeout_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Inactivity timer and per-client block flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= 16'd0;
      blk_q   <= 2'b00;
    end else begin
      timer_q <= timer_d;
      blk_q   <= blk_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: vector table with scoreboard, hand-written corner
// sequences (one-cycle request, async reset, timeout/hold) and random traffic.
module tb_i2c_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, gnt0, gnt1;
  logic       start0, start1, send0, send1, receive0, receive1;
  logic [7:0] datasend0, datasend1;
  logic       sended0, sended1, received0, received1;
  logic [7:0] datareceive0, datareceive1;
  logic       m_start, m_send, m_receive;
  logic [7:0] m_datasend;
  logic       m_ready, m_sended, m_received;
  logic [7:0] m_datareceive;
  logic       busy, owner, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .start0(start0), .start1(start1), .send0(send0), .send1(send1),
    .receive0(receive0), .receive1(receive1),
    .datasend0(datasend0), .datasend1(datasend1),
    .sended0(sended0), .sended1(sended1),
    .received0(received0), .received1(received1),
    .datareceive0(datareceive0), .datareceive1(datareceive1),
    .m_start(m_start), .m_send(m_send), .m_receive(m_receive),
    .m_datasend(m_datasend), .m_ready(m_ready), .m_sended(m_sended),
    .m_received(m_received), .m_datareceive(m_datareceive),
    .busy(busy), .owner(owner), .timeout(timeout)
  );

  typedef struct {
    logic       r0, r1, rdy, st0, st1, sn0, sn1;
    logic [7:0] d0, d1;
    logic       msd;
    logic [7:0] mdr;
    logic       g0, g1, bsy, own, mst, msn;
    logic [7:0] mds;
    logic       sd0, sd1;
    logic [7:0] dr0, dr1;
  } vec_t;

  vec_t vecs[20];
  vec_t sb_q[$];

  function automatic vec_t mk(
    input logic r0, r1, rdy, st0, st1, sn0, sn1,
    input logic [7:0] d0, d1, input logic msd, input logic [7:0] mdr,
    input logic g0, g1, bsy, own, mst, msn, input logic [7:0] mds,
    input logic sd0, sd1, input logic [7:0] dr0, dr1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.st0 = st0; v.st1 = st1;
    v.sn0 = sn0; v.sn1 = sn1; v.d0 = d0; v.d1 = d1; v.msd = msd; v.mdr = mdr;
    v.g0 = g0; v.g1 = g1; v.bsy = bsy; v.own = own; v.mst = mst; v.msn = msn;
    v.mds = mds; v.sd0 = sd0; v.sd1 = sd1; v.dr0 = dr0; v.dr1 = dr1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; start0 = 0; start1 = 0; send0 = 0; send1 = 0;
    receive0 = 0; receive1 = 0; datasend0 = 0; datasend1 = 0;
    m_ready = 1; m_sended = 0; m_received = 0; m_datareceive = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   hit;

    // Vector table: outputs sampled in the same cycle as the inputs, so
    // grants reflect the previous edge and steered paths reflect this cycle.
    vecs[0] = mk(1,1,1, 0,0,0,0, 8'h00,8'h00, 0,8'h3C, 0,0,0,0, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[1] = mk(1,1,1, 1,1,0,0, 8'h11,8'h22, 0,8'h3C, 1,0,1,0, 1,0,8'h11, 0,0, 8'h3C,8'h00);
    vecs[2] = mk(0,1,1, 0,0,1,1, 8'h5A,8'h00, 1,8'h77, 1,0,1,0, 0,1,8'h5A, 1,0, 8'h77,8'h00);
    vecs[3] = mk(0,1,1, 0,1,0,0, 8'h00,8'h00, 1,8'h00, 0,0,1,0, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[4] = mk(0,1,1, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[5] = mk(1,1,1, 0,0,1,1, 8'h33,8'hA5, 1,8'h99, 0,1,1,1, 0,1,8'hA5, 0,1, 8'h00,8'h99);
    vecs[6] = mk(1,0,0, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 0,1,1,1, 0,0,8'h00, 0,0, 8'h00,8'h00);
    for (int i = 7; i < 17; i++)
      vecs[i] = mk(1,0,0, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 0,0,1,1, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[17] = mk(1,0,1, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 0,0,1,1, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[18] = mk(1,0,1, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 0,0,0,1, 0,0,8'h00, 0,0, 8'h00,8'h00);
    vecs[19] = mk(1,1,1, 0,0,0,0, 8'h00,8'h00, 0,8'h00, 1,0,1,0, 0,0,8'h00, 0,0, 8'h00,8'h00);

    // Reset state, with active inputs that must not leak through.
    clear_inputs();
    reset = 0;
    req0 = 1; start0 = 1; send0 = 1; m_sended = 1; m_received = 1;
    m_datareceive = 8'hFF; datasend0 = 8'hC3;
    #3;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_datasend", m_datasend, 8'h00);
    chk("rst_sended0", sended0, 0);
    chk("rst_received0", received0, 0);
    chk("rst_datareceive0", datareceive0, 8'h00);
    do_reset();

    // Table pass with scoreboard.
    for (int i = 0; i < 20; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1; m_ready = vecs[i].rdy;
      start0 = vecs[i].st0; start1 = vecs[i].st1;
      send0 = vecs[i].sn0; send1 = vecs[i].sn1;
      datasend0 = vecs[i].d0; datasend1 = vecs[i].d1;
      m_sended = vecs[i].msd; m_datareceive = vecs[i].mdr;
      sb_q.push_back(vecs[i]);
      #3;
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty v%0d: got 0 entries expected 1", i);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_gnt0", i), gnt0, e.g0);
        chk($sformatf("v%0d_gnt1", i), gnt1, e.g1);
        chk($sformatf("v%0d_busy", i), busy, e.bsy);
        chk($sformatf("v%0d_owner", i), owner, e.own);
        chk($sformatf("v%0d_m_start", i), m_start, e.mst);
        chk($sformatf("v%0d_m_send", i), m_send, e.msn);
        chk($sformatf("v%0d_m_datasend", i), m_datasend, e.mds);
        chk($sformatf("v%0d_sended0", i), sended0, e.sd0);
        chk($sformatf("v%0d_sended1", i), sended1, e.sd1);
        chk($sformatf("v%0d_datareceive0", i), datareceive0, e.dr0);
        chk($sformatf("v%0d_datareceive1", i), datareceive1, e.dr1);
      end
      tick();
    end

    // One-cycle request pulse in IDLE: one-cycle grant, then DRAIN.
    do_reset();
    req1 = 1;
    tick();
    req1 = 0;
    #3;
    chk("pulse_gnt1", gnt1, 1);
    chk("pulse_owner", owner, 1);
    tick();
    #3;
    chk("pulse_gnt1_drop", gnt1, 0);
    chk("pulse_drain_busy", busy, 1);
    tick();
    #3;
    chk("pulse_idle_busy", busy, 0);

    // Asynchronous reset while a grant is active.
    do_reset();
    req0 = 1; start0 = 1;
    tick();
    #3;
    chk("arst_pre_m_start", m_start, 1);
    #1;
    reset = 0;
    #1;
    chk("arst_gnt0", gnt0, 0);
    chk("arst_m_start", m_start, 0);
    chk("arst_busy", busy, 0);
    tick();
    reset = 1;
    clear_inputs();

`ifdef I2C_ARB_TIMEOUT_EN
    // Idle owner is released after TIMEOUT_CYCLES and blocked until req low.
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    hit = 0;
    for (int i = 1; i <= 40 && hit == 0; i++) begin
      tick();
      #3;
      if (timeout === 1'b1) hit = i;
    end
    chk("to_cycle", 8'(hit), 8'd16);
    chk("to_gnt0", gnt0, 0);
    tick();
    #3;
    chk("to_pulse_width", timeout, 0);
    tick();
    #3;
    chk("to_gnt1", gnt1, 1);
    chk("to_gnt0_blocked", gnt0, 0);
    req1 = 0;
    tick();
    tick();
    tick();
    #3;
    chk("to_req0_ignored_gnt0", gnt0, 0);
    chk("to_req0_ignored_busy", busy, 0);
    req0 = 0;
    tick();
    req0 = 1;
    tick();
    #3;
    chk("to_unblock_gnt0", gnt0, 1);
`else
    // Without the timer a quiet owner keeps the grant indefinitely.
    do_reset();
    req0 = 1; req1 = 1;
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout === 1'b1) hit++;
    end
    #3;
    chk("hold_gnt0", gnt0, 1);
    chk("hold_gnt1", gnt1, 0);
    chk("hold_timeout_cnt", 8'(hit), 8'd0);
`endif

    // Random traffic with invariant checks.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 15) == 0) req0 = ~req0;
      if ($urandom_range(0, 15) == 0) req1 = ~req1;
      m_ready = ($urandom_range(0, 3) != 0);
      start0 = 1'($urandom); start1 = 1'($urandom);
      send0 = 1'($urandom); send1 = 1'($urandom);
      receive0 = 1'($urandom); receive1 = 1'($urandom);
      datasend0 = 8'($urandom); datasend1 = 8'($urandom);
      m_sended = ($urandom_range(0, 7) == 0);
      m_received = ($urandom_range(0, 7) == 0);
      m_datareceive = 8'($urandom);
      #3;
      chk($sformatf("rnd%0d_onehot", c), gnt0 & gnt1, 0);
      if (busy === 1'b0)
        chk($sformatf("rnd%0d_idle_ctrl", c),
            {m_start, m_send, m_receive, 5'd0} | m_datasend, 8'h00);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
